// File: rtl/gcd_pkg.sv
// Shared state encoding, algorithm selectors and sizing helper for the GCD engine.
package gcd_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_CALC   = 2'd1;
  localparam state_t ST_FINISH = 2'd2;

  localparam int ALGO_EUCLID = 0;
  localparam int ALGO_STEIN  = 1;

  // Width of the shared power-of-two exponent k used by the binary algorithm.
  function automatic int k_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/gcd_step.sv
// Combinational single-iteration unit: termination detect, scaled result and next operand values.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ALGO  = ALGO_EUCLID,
  parameter int KW    = k_width(WIDTH)
) (
  input  logic [WIDTH-1:0] a_cur,
  input  logic [WIDTH-1:0] b_cur,
  input  logic [KW-1:0]    k_cur,
  output logic [WIDTH-1:0] a_nxt,
  output logic [WIDTH-1:0] b_nxt,
  output logic [KW-1:0]    k_nxt,
  output logic             term,
  output logic             zero_both,
  output logic [WIDTH-1:0] result
);

  logic             a_zero;
  logic             b_zero;
  logic             a_gt_b;
  logic [WIDTH-1:0] diff_ab;
  logic [WIDTH-1:0] diff_ba;
  logic [WIDTH-1:0] base;

  assign a_zero  = (a_cur == '0);
  assign b_zero  = (b_cur == '0);
  assign a_gt_b  = (a_cur > b_cur);
  // Each difference is only consumed when its minuend is the larger operand.
  assign diff_ab = a_cur - b_cur;
  assign diff_ba = b_cur - a_cur;

  always_comb begin
    zero_both = a_zero && b_zero;
    term      = a_zero || b_zero || (a_cur == b_cur);
    base      = a_zero ? b_cur : a_cur;
    a_nxt     = a_cur;
    b_nxt     = b_cur;
    k_nxt     = k_cur;
    result    = base;
    if (ALGO == ALGO_STEIN) begin
      // Shared factors of two removed earlier are restored on the way out.
      result = base << k_cur;
      if (!term) begin
        case ({a_cur[0], b_cur[0]})
          2'b00: begin
            a_nxt = a_cur >> 1;
            b_nxt = b_cur >> 1;
            k_nxt = k_cur + 1'b1;
          end
          2'b01:   a_nxt = a_cur >> 1;
          2'b10:   b_nxt = b_cur >> 1;
          default: begin
            if (a_gt_b) a_nxt = diff_ab >> 1;
            else        b_nxt = diff_ba >> 1;
          end
        endcase
      end
    end else begin
      if (!term) begin
        if (a_gt_b) a_nxt = diff_ab;
        else        b_nxt = diff_ba;
      end
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// Iterative GCD engine: start/done handshake, busy flag, zero-operand flag and iteration counter.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ALGO  = ALGO_EUCLID,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] gcd,
  output logic             zero_err,
  output logic [CNT_W-1:0] iters
);

  localparam int KW = k_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [KW-1:0]    shift_k;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;
  logic [KW-1:0]    k_nxt;
  logic             term;
  logic             zero_both;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign cnt_inc = sat_inc(cnt);

  gcd_step #(
    .WIDTH (WIDTH),
    .ALGO  (ALGO),
    .KW    (KW)
  ) u_step (
    .a_cur     (op_a),
    .b_cur     (op_b),
    .k_cur     (shift_k),
    .a_nxt     (a_nxt),
    .b_nxt     (b_nxt),
    .k_nxt     (k_nxt),
    .term      (term),
    .zero_both (zero_both),
    .result    (result)
  );

  // Published iters is loaded only at completion so it holds like gcd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      gcd      <= '0;
      zero_err <= 1'b0;
      iters    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      shift_k  <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_a    <= a;
            op_b    <= b;
            shift_k <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= ST_CALC;
          end
        end
        ST_CALC: begin
          cnt <= cnt_inc;
          if (term) begin
            gcd      <= result;
            zero_err <= zero_both;
            iters    <= cnt_inc;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= ST_FINISH;
          end else begin
            op_a    <= a_nxt;
            op_b    <= b_nxt;
            shift_k <= k_nxt;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_engine.sv
// Directed and randomised bench for gcd_engine across Euclid/Stein and 16/32-bit builds.
module tb_gcd_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_v [3];
  logic [31:0] a_v     [3];
  logic [31:0] b_v     [3];
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [2:0]  zerr_v;
  logic [15:0] iters_v [3];
  logic [31:0] gcd_v   [3];
  logic [15:0] g0, g1;
  logic [31:0] g2;

  logic [31:0] prev_g  [3];
  logic [15:0] prev_it [3];
  logic        prev_z  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gcd_engine #(.WIDTH(16), .ALGO(0), .CNT_W(16)) u_e16 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0][15:0]), .b(b_v[0][15:0]),
    .busy(busy_v[0]), .done(done_v[0]), .gcd(g0), .zero_err(zerr_v[0]), .iters(iters_v[0]));

  gcd_engine #(.WIDTH(16), .ALGO(1), .CNT_W(16)) u_s16 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1][15:0]), .b(b_v[1][15:0]),
    .busy(busy_v[1]), .done(done_v[1]), .gcd(g1), .zero_err(zerr_v[1]), .iters(iters_v[1]));

  gcd_engine #(.WIDTH(32), .ALGO(1), .CNT_W(16)) u_s32 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .gcd(g2), .zero_err(zerr_v[2]), .iters(iters_v[2]));

  assign gcd_v[0] = {16'h0, g0};
  assign gcd_v[1] = {16'h0, g1};
  assign gcd_v[2] = g2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_gcd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] p, q, t;
    p = x;
    q = y;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // One transaction on instance id; lat counts edges from the start edge (inclusive) to done.
  task automatic run(input int id, input logic [31:0] ia, input logic [31:0] ib,
                     output logic [31:0] g, output logic z, output logic [15:0] it,
                     output int lat, output int bcnt);
    @(negedge clk);
    a_v[id] = ia;
    b_v[id] = ib;
    start_v[id] = 1'b1;
    @(negedge clk);
    start_v[id] = 1'b0;
    lat = 1;
    bcnt = 0;
    check("hold_gcd", gcd_v[id], prev_g[id]);
    check("hold_iters", {16'h0, iters_v[id]}, {16'h0, prev_it[id]});
    check("hold_zerr", {31'h0, zerr_v[id]}, {31'h0, prev_z[id]});
    while (!done_v[id] && lat < 5000) begin
      if (busy_v[id]) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (!done_v[id]) check("timeout", {31'h0, done_v[id]}, 32'h1);
    g  = gcd_v[id];
    z  = zerr_v[id];
    it = iters_v[id];
    prev_g[id]  = g;
    prev_z[id]  = z;
    prev_it[id] = it;
  endtask

  initial begin
    logic [31:0] g, ra, rb;
    logic        z;
    logic [15:0] it;
    int          lat, bcnt, dcnt;
    bit          fin_seen;

    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      a_v[i] = '0;
      b_v[i] = '0;
      prev_g[i] = '0;
      prev_it[i] = '0;
      prev_z[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'h0, busy_v[0]}, 32'h0);
    check("rst_done", {31'h0, done_v[0]}, 32'h0);
    check("rst_gcd", gcd_v[0], 32'h0);
    check("rst_zerr", {31'h0, zerr_v[0]}, 32'h0);
    check("rst_iters", {16'h0, iters_v[0]}, 32'h0);

    // Euclid 48,36: 48-36=12, 36-12=24, 24-12=12, equal -> 4 iterations
    run(0, 48, 36, g, z, it, lat, bcnt);
    check("e_48_36_gcd", g, 12);
    check("e_48_36_iters", {16'h0, it}, 4);
    check("e_48_36_zerr", {31'h0, z}, 0);
    check("e_48_36_latency", lat, 5);
    check("e_48_36_busy_cycles", bcnt, 4);
    check("e_48_36_done_busy", {31'h0, busy_v[0]}, 0);

    run(1, 48, 36, g, z, it, lat, bcnt);
    check("s_48_36_gcd", g, 12);
    check("s_48_36_iters", {16'h0, it}, 6);
    run(1, 65535, 1, g, z, it, lat, bcnt);
    check("s_ffff_1_gcd", g, 1);
    check("s_ffff_1_iters", {16'h0, it}, 16);

    for (int id = 0; id < 2; id++) begin
      run(id, 0, 0, g, z, it, lat, bcnt);
      check("zero_zero_gcd", g, 0);
      check("zero_zero_zerr", {31'h0, z}, 1);
      check("zero_zero_iters", {16'h0, it}, 1);
      run(id, 0, 25, g, z, it, lat, bcnt);
      check("zero_25_gcd", g, 25);
      check("zero_25_zerr", {31'h0, z}, 0);
      check("zero_25_iters", {16'h0, it}, 1);
      run(id, 7, 0, g, z, it, lat, bcnt);
      check("7_zero_gcd", g, 7);
      check("7_zero_zerr", {31'h0, z}, 0);
      check("7_zero_iters", {16'h0, it}, 1);
    end

    // Start pulses during CALC and during FINISH must both be dropped.
    @(negedge clk);
    a_v[0] = 100;
    b_v[0] = 75;
    start_v[0] = 1'b1;
    dcnt = 0;
    fin_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
      if (done_v[0]) dcnt++;
      if (i == 1 || (done_v[0] && !fin_seen)) begin
        a_v[0] = 9;
        b_v[0] = 6;
        start_v[0] = 1'b1;
      end
      if (done_v[0]) fin_seen = 1;
    end
    check("ign_done_count", dcnt, 1);
    check("ign_gcd", gcd_v[0], 25);
    check("ign_iters", {16'h0, iters_v[0]}, 4);
    check("ign_busy", {31'h0, busy_v[0]}, 0);
    prev_g[0] = 25;
    prev_it[0] = 4;
    prev_z[0] = 1'b0;
    run(0, 9, 6, g, z, it, lat, bcnt);
    check("after_ign_gcd", g, 3);

    // Asynchronous abort in the middle of a long subtractive run.
    @(negedge clk);
    a_v[0] = 1000;
    b_v[0] = 1;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_busy_before", {31'h0, busy_v[0]}, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", {31'h0, busy_v[0]}, 0);
    check("abort_gcd", gcd_v[0], 0);
    check("abort_iters", {16'h0, iters_v[0]}, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      prev_g[i] = '0;
      prev_it[i] = '0;
      prev_z[i] = 1'b0;
    end
    dcnt = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (done_v[0]) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    check("abort_busy_after", {31'h0, busy_v[0]}, 0);

    run(2, 32'hFFFF_FFFE, 32'h8000_0000, g, z, it, lat, bcnt);
    check("s32_fffffffe_gcd", g, 2);
    check("s32_fffffffe_zerr", {31'h0, z}, 0);

    fork
      begin
        logic [31:0] eg, ea, eb;
        logic        ez;
        logic [15:0] eit;
        int          el, eb_cnt;
        for (int n = 0; n < 1000; n++) begin
          ea = $urandom_range(0, 63);
          eb = $urandom_range(0, 63);
          run(0, ea, eb, eg, ez, eit, el, eb_cnt);
          check("rand_e16_gcd", eg, ref_gcd(ea, eb));
          check("rand_e16_zerr", {31'h0, ez}, {31'h0, (ea == 0 && eb == 0)});
        end
      end
      begin
        logic [31:0] sg, sa, sb;
        logic        sz;
        logic [15:0] sit;
        int          sl, sb_cnt, sh;
        for (int n = 0; n < 1000; n++) begin
          sa = $urandom;
          sb = $urandom;
          if (n % 4 == 0) begin
            sh = $urandom_range(0, 8);
            sa = ($urandom & 32'hFFFF) << sh;
            sb = ($urandom & 32'hFFFF) << sh;
          end
          run(2, sa, sb, sg, sz, sit, sl, sb_cnt);
          check("rand_s32_gcd", sg, ref_gcd(sa, sb));
          check("rand_s32_zerr", {31'h0, sz}, {31'h0, (sa == 0 && sb == 0)});
        end
      end
    join

    ra = 32'd0;
    rb = 32'd0;
    run(1, 1071, 462, g, z, it, lat, bcnt);
    ra = g;
    run(0, 1071, 462, g, z, it, lat, bcnt);
    rb = g;
    check("cross_1071_462_stein", ra, 21);
    check("cross_1071_462_euclid", rb, 21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
